seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one BCD2SEG7-style BCD-to-7-segment decoder across DIGITS common-anode digits on the Basys3 display.
- Sequences one digit per time slot, most-significant digit first, and drives the decoder's BCD, LT, RBI and BI inputs plus the digit anodes.
- Computes leading-zero suppression (RBI) per slot, inserts anti-ghosting blanking guard time, and double-buffers display data so updates commit only at frame boundaries.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- TICK_DIV, 100000, clock cycles per digit slot (>= GUARD+2).
- GUARD, 16, cycles at the start of each slot with all anodes off and BI asserted (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  capture bcd_in/dp_in into the pending buffer.
- bcd_in  in  4*DIGITS  digit k at [4k+3:4k]; digit 0 is least significant.
- dp_in  in  DIGITS  decimal point request per digit, active-high.
- lz_en  in  1  leading-zero suppression enable.
- lamp_test  in  1  asynchronous lamp-test request, active-high.
- bcd_out  out  4  BCD {d,c,b,a} to the shared decoder.
- lt_n  out  1  decoder lamp-test input, active-low.
- rbi_n  out  1  decoder ripple-blanking input, active-low.
- bi_n  out  1  decoder blanking input, active-low; low blanks all segments.
- an  out  DIGITS  anode enables, active-low; at most one bit low.
- dp_n  out  1  decimal point segment, active-low.
- digit_idx  out  $clog2(DIGITS)  index of the digit in the current slot.
- frame_start  out  1  one-cycle pulse at slot 0 of digit DIGITS-1.
- pending  out  1  buffered data waiting for a frame boundary.

Behaviour:
- Every output is registered; there is no combinational path from inputs to outputs.
- Reset (async, rst_n=0):
  - slot counter s=0, digit_idx=DIGITS-1, display and pending buffers zero, pending=0.
  - Outputs: an all 1, bi_n=0, lt_n=1, rbi_n=1, bcd_out=0, dp_n=1, frame_start=0.
  - Releasing rst_n starts scanning at digit DIGITS-1, slot cycle 0.
- Slot counter:
  - s counts 0..TICK_DIV-1.
  - On wrap, digit_idx decrements; at 0 it wraps to DIGITS-1.
  - Frame period = DIGITS*TICK_DIV cycles.
- Within a slot (two-state FSM, GUARD then SHOW):
  - GUARD (s < GUARD): an all 1, bi_n=0.
  - SHOW (s >= GUARD): an[digit_idx]=0 with all other bits 1, bi_n=1.
  - bcd_out, rbi_n and dp_n update only at s==0 and stay stable for the whole slot.
- Leading-zero suppression, evaluated at s==0 from the display buffer:
  - For digit_idx>0: rbi_n = ~(lz_en & all display digits above digit_idx equal 0).
  - For the most-significant digit that means rbi_n = ~lz_en.
  - For digit_idx==0: rbi_n=1 always, so a zero value still shows "0".
  - The decoder blanks a digit only when rbi_n=0 and BCD=0; nonzero digits show regardless of rbi_n.
- Decimal point: dp_n = ~display_dp[digit_idx].
- Double buffering:
  - load=1 writes bcd_in/dp_in into the pending buffer and sets pending=1.
  - A second load before the boundary overwrites the pending buffer (newest wins).
  - At a frame boundary (the cycle s wraps while digit_idx==0), display <= pending buffer and pending <= 0, provided pending=1 or load=1.
  - If load coincides with the boundary, display takes bcd_in/dp_in directly and pending=0.
  - frame_start pulses the following cycle; the new data appears from that slot onward.
  - The display buffer never changes mid-frame.
- Lamp test:
  - lamp_test passes through a 2-flop synchronizer; lt_n = ~synced value (2–3 cycle latency).
  - While lamp test is active: dp_n=0 during SHOW, scanning continues, guard blanking still applies (bi_n=0).
- BCD values 10–15 pass through unmodified; decoding is the decoder's job.

Test Plan:
- Use TICK_DIV=8, GUARD=2, DIGITS=4 throughout.
- Reset mid-frame: assert rst_n=0 at s=5, digit 1 → an=4'b1111, bi_n=0, digit_idx=3 immediately. After release, the first anode low is an=4'b0111 at s=2.
- Load 16'h0042 with lz_en=1 → after frame_start, rbi_n sequence per digit 3..0 is 0,0,0,1; bcd_out sequence is 0,0,4,2.
- Load 16'h0000 with lz_en=1 → rbi_n sequence is 0,0,0,1 (last digit shows "0"). Load 16'h1005 → rbi_n sequence is 0,1,1,1.
- Load 16'h1234 at digit 2, s=3 → pending=1 and bcd_out unchanged for the rest of the frame. At the boundary, pending=0, frame_start=1, and the next slot shows bcd_out=1.
- Load 16'h9876 exactly on the boundary cycle while pending holds 16'h1111 → the display shows 9,8,7,6 and pending=0.
- Raise lamp_test → lt_n=0 within 3 cycles; dp_n=0 during SHOW; an and bi_n keep guard timing (2 cycles blank, 6 cycles lit per slot).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a shared BCD-to-7-segment decoder.
// Drives anodes MSD-first with guard blanking, leading-zero RBI and frame-synchronous data commit.
module seg7_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*DIGITS-1:0]       bcd_in,
    input  logic [DIGITS-1:0]         dp_in,
    input  logic                      lz_en,
    input  logic                      lamp_test,
    output logic [3:0]                bcd_out,
    output logic                      lt_n,
    output logic                      rbi_n,
    output logic                      bi_n,
    output logic [DIGITS-1:0]         an,
    output logic                      dp_n,
    output logic [$clog2(DIGITS)-1:0] digit_idx,
    output logic                      frame_start,
    output logic                      pending
);

    localparam int IW = $clog2(DIGITS);
    localparam int SW = $clog2(TICK_DIV);
    localparam logic [SW-1:0] S_LAST  = SW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_GUARD = SW'(GUARD);
    localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);

    typedef enum logic {ST_GUARD, ST_SHOW} state_t;

    state_t              state, state_nx;
    logic [SW-1:0]       s, s_nx;
    logic [IW-1:0]       idx_nx;
    logic [4*DIGITS-1:0] disp_bcd, disp_bcd_nx, pend_bcd, pend_bcd_nx;
    logic [DIGITS-1:0]   disp_dp, disp_dp_nx, pend_dp, pend_dp_nx;
    logic                pending_nx;
    logic                lt_sync;
    logic                wrap, upper_zero;
    logic [3:0]          bcd_nx;
    logic                rbi_nx, dp_nx, bi_nx, fs_nx;
    logic [DIGITS-1:0]   an_nx;

    // Outputs are computed from the next slot position so the registered
    // outputs always line up with the registered s/digit_idx.
    always_comb begin
        wrap   = (s == S_LAST);
        s_nx   = wrap ? '0 : s + 1'b1;
        idx_nx = digit_idx;
        if (wrap)
            idx_nx = (digit_idx == '0) ? IDX_TOP : digit_idx - 1'b1;

        disp_bcd_nx = disp_bcd;
        disp_dp_nx  = disp_dp;
        pend_bcd_nx = pend_bcd;
        pend_dp_nx  = pend_dp;
        pending_nx  = pending;
        if (wrap && (digit_idx == '0) && (pending || load)) begin
            disp_bcd_nx = load ? bcd_in : pend_bcd;
            disp_dp_nx  = load ? dp_in  : pend_dp;
            pending_nx  = 1'b0;
        end else if (load) begin
            pend_bcd_nx = bcd_in;
            pend_dp_nx  = dp_in;
            pending_nx  = 1'b1;
        end

        state_nx = state;
        case (state)
            ST_GUARD: if (s_nx >= S_GUARD) state_nx = ST_SHOW;
            ST_SHOW:  if (s_nx == '0)      state_nx = ST_GUARD;
            default:  state_nx = ST_GUARD;
        endcase

        an_nx = '1;
        bi_nx = 1'b0;
        if (state_nx == ST_SHOW) begin
            an_nx[idx_nx] = 1'b0;
            bi_nx         = 1'b1;
        end

        upper_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++)
            if ((k > 32'(idx_nx)) && (disp_bcd_nx[4*k +: 4] != 4'd0))
                upper_zero = 1'b0;

        bcd_nx = bcd_out;
        rbi_nx = rbi_n;
        if (s_nx == '0) begin
            bcd_nx = disp_bcd_nx[4*idx_nx +: 4];
            rbi_nx = (idx_nx == '0) | ~(lz_en & upper_zero);
        end

        dp_nx = ~((lt_sync & (state_nx == ST_SHOW)) | disp_dp_nx[idx_nx]);
        fs_nx = (s_nx == '0) && (idx_nx == IDX_TOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_GUARD;
            s           <= '0;
            digit_idx   <= IDX_TOP;
            disp_bcd    <= '0;
            disp_dp     <= '0;
            pend_bcd    <= '0;
            pend_dp     <= '0;
            pending     <= 1'b0;
            lt_sync     <= 1'b0;
            lt_n        <= 1'b1;
            an          <= '1;
            bi_n        <= 1'b0;
            rbi_n       <= 1'b1;
            bcd_out     <= '0;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            s           <= s_nx;
            digit_idx   <= idx_nx;
            disp_bcd    <= disp_bcd_nx;
            disp_dp     <= disp_dp_nx;
            pend_bcd    <= pend_bcd_nx;
            pend_dp     <= pend_dp_nx;
            pending     <= pending_nx;
            lt_sync     <= lamp_test;
            lt_n        <= ~lt_sync;
            an          <= an_nx;
            bi_n        <= bi_nx;
            rbi_n       <= rbi_nx;
            bcd_out     <= bcd_nx;
            dp_n        <= dp_nx;
            frame_start <= fs_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: table vectors, corner sequences and random stimulus
// compared every cycle against a slot/frame arithmetic reference model.
module tb_seg7_scan_ctrl;

    localparam int DG = 4;
    localparam int TD = 8;
    localparam int GD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic          lz_en;
    logic          lamp_test;
    logic [3:0]    bcd_out;
    logic          lt_n, rbi_n, bi_n, dp_n, frame_start, pending;
    logic [3:0]    an;
    logic [1:0]    digit_idx;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(.DIGITS(DG), .TICK_DIV(TD), .GUARD(GD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .lz_en(lz_en), .lamp_test(lamp_test), .bcd_out(bcd_out), .lt_n(lt_n),
        .rbi_n(rbi_n), .bi_n(bi_n), .an(an), .dp_n(dp_n), .digit_idx(digit_idx),
        .frame_start(frame_start), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: position t cycles after reset, digit arrays for buffers.
    int  t;
    int  md[DG];
    int  mp[DG];
    bit  [3:0] mdp, mpdp;
    bit  mpend, lt_h, lt_prev;
    int  e_bcd;
    bit  e_rbi;

    function automatic int m_s();
        return t % TD;
    endfunction

    function automatic int m_dg();
        return DG - 1 - (t / TD) % DG;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (time %0t, model t=%0d)", name, act, exp, $time, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int k = 0; k < DG; k++) begin
            md[k] = 0;
            mp[k] = 0;
        end
        mdp = '0; mpdp = '0; mpend = 0;
        lt_h = 0; lt_prev = 0;
        e_bcd = 0; e_rbi = 1;
    endtask

    task automatic model_step();
        int s, dg;
        bit uz;
        s  = m_s();
        dg = m_dg();
        if (s == TD - 1 && dg == 0 && (load || mpend)) begin
            for (int k = 0; k < DG; k++) md[k] = load ? int'(bcd_in[4*k +: 4]) : mp[k];
            mdp   = load ? dp_in : mpdp;
            mpend = 0;
        end else if (load) begin
            for (int k = 0; k < DG; k++) mp[k] = int'(bcd_in[4*k +: 4]);
            mpdp  = dp_in;
            mpend = 1;
        end
        lt_prev = lt_h;
        lt_h    = lamp_test;
        t++;
        s  = m_s();
        dg = m_dg();
        if (s == 0) begin
            uz = 1;
            for (int k = dg + 1; k < DG; k++) if (md[k] != 0) uz = 0;
            e_bcd = md[dg];
            e_rbi = (dg == 0) || !(lz_en && uz);
        end
    endtask

    task automatic check_all();
        int s, dg;
        s  = m_s();
        dg = m_dg();
        chk("an", an, (s < GD) ? 32'hF : (32'hF ^ (32'h1 << dg)));
        chk("bi_n", bi_n, s >= GD);
        chk("lt_n", lt_n, !lt_prev);
        chk("dp_n", dp_n, (lt_prev && s >= GD) ? 0 : !mdp[dg]);
        chk("digit_idx", digit_idx, dg);
        chk("frame_start", frame_start, (s == 0) && (dg == DG - 1));
        chk("pending", pending, mpend);
        chk("bcd_out", bcd_out, e_bcd);
        chk("rbi_n", rbi_n, e_rbi);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // dg < 0 means any digit
    task automatic run_to(input int dg, input int s);
        int n;
        n = 0;
        while (!((dg < 0 || m_dg() == dg) && m_s() == s) && n < 40) begin
            cycle();
            n++;
        end
        chk("run_to_reached", ((dg < 0 || m_dg() == dg) && m_s() == s), 1);
    endtask

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  exp_rbi;   // bit k = expected rbi_n for digit k
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{bcd: 16'h0042, dp: 4'b0000, lz: 1'b1, exp_rbi: 4'b0001};
        vt[1] = '{bcd: 16'h0000, dp: 4'b0010, lz: 1'b1, exp_rbi: 4'b0001};
        vt[2] = '{bcd: 16'h1005, dp: 4'b1000, lz: 1'b1, exp_rbi: 4'b0111};
        vt[3] = '{bcd: 16'h0042, dp: 4'b0101, lz: 1'b0, exp_rbi: 4'b1111};
        vt[4] = '{bcd: 16'h00A0, dp: 4'b0001, lz: 1'b1, exp_rbi: 4'b0001};
        vt[5] = '{bcd: 16'h0807, dp: 4'b1111, lz: 1'b1, exp_rbi: 4'b0011};

        rst_n = 0; load = 0; bcd_in = '0; dp_in = '0; lz_en = 1; lamp_test = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_bi_n", bi_n, 0);
        chk("rst_lt_n", lt_n, 1);
        chk("rst_rbi_n", rbi_n, 1);
        chk("rst_bcd_out", bcd_out, 0);
        chk("rst_dp_n", dp_n, 1);
        chk("rst_digit_idx", digit_idx, 3);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_pending", pending, 0);
        rst_n = 1;

        // Mid-frame asynchronous reset at digit 1, s=5
        run_to(1, 5);
        rst_n = 0;
        #1;
        chk("midrst_an", an, 4'hF);
        chk("midrst_bi_n", bi_n, 0);
        chk("midrst_digit_idx", digit_idx, 3);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        cycle();
        chk("post_rst_s1_an", an, 4'hF);
        cycle();
        chk("post_rst_s2_an", an, 4'b0111);

        // Table vectors: load, wait for frame_start, check each slot MSD first
        foreach (vt[i]) begin
            int n;
            lz_en  = vt[i].lz;
            bcd_in = vt[i].bcd;
            dp_in  = vt[i].dp;
            load   = 1;
            cycle();
            load = 0;
            n = 0;
            while (!frame_start && n < 40) begin
                cycle();
                n++;
            end
            chk("vec_frame_start_seen", frame_start, 1);
            for (int d = DG - 1; d >= 0; d--) begin
                chk("vec_bcd_out", bcd_out, vt[i].bcd[4*d +: 4]);
                chk("vec_rbi_n", rbi_n, vt[i].exp_rbi[d]);
                chk("vec_dp_n", dp_n, !vt[i].dp[d]);
                repeat (TD) cycle();
            end
        end

        // Mid-frame load must wait for the frame boundary
        run_to(2, 3);
        bcd_in = 16'h1234; dp_in = 4'b0000; load = 1;
        cycle();
        load = 0;
        chk("mid_load_pending", pending, 1);
        begin
            int n;
            n = 0;
            while (!(m_dg() == 0 && m_s() == TD - 1) && n < 40) begin
                chk("mid_load_bcd_held", bcd_out, vt[5].bcd[4*m_dg() +: 4]);
                cycle();
                n++;
            end
        end
        chk("boundary_pending_before", pending, 1);
        cycle();
        chk("boundary_pending_after", pending, 0);
        chk("boundary_frame_start", frame_start, 1);
        chk("boundary_bcd_out", bcd_out, 1);

        // Load coinciding with the boundary overrides a pending 1111
        run_to(2, 0);
        bcd_in = 16'h1111; load = 1;
        cycle();
        load = 0;
        run_to(0, TD - 1);
        chk("pre_coincide_pending", pending, 1);
        bcd_in = 16'h9876; load = 1;
        cycle();
        load = 0;
        chk("coincide_pending", pending, 0);
        begin
            logic [15:0] exp_seq;
            exp_seq = 16'h9876;
            for (int d = DG - 1; d >= 0; d--) begin
                chk("coincide_bcd_out", bcd_out, exp_seq[4*d +: 4]);
                repeat (TD) cycle();
            end
        end

        // Lamp test: latency, dp forced during SHOW, guard timing preserved
        dp_in = '0;
        lamp_test = 1;
        begin
            int n, lit, blank;
            n = 0;
            while (lt_n && n < 3) begin
                cycle();
                n++;
            end
            chk("lamp_lt_n_latency", lt_n, 0);
            run_to(-1, TD - 1);
            lit = 0; blank = 0;
            for (int c = 0; c < TD; c++) begin
                cycle();
                if (an == 4'hF) begin
                    blank++;
                    chk("lamp_guard_bi_n", bi_n, 0);
                end else begin
                    lit++;
                    chk("lamp_show_dp_n", dp_n, 0);
                end
            end
            chk("lamp_blank_cycles", blank, GD);
            chk("lamp_lit_cycles", lit, TD - GD);
        end
        lamp_test = 0;

        // Randomized stimulus against the model
        for (int c = 0; c < 500; c++) begin
            load   = ($urandom % 10) == 0;
            bcd_in = 16'($urandom);
            dp_in  = 4'($urandom);
            if (($urandom % 4) == 0) bcd_in[15:8] = 8'h00;
            if (($urandom % 40) == 0) lz_en = ~lz_en;
            if (($urandom % 60) == 0) lamp_test = ~lamp_test;
            cycle();
        end
        load = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
